feedback_echo: RTL

- Parametrised successor to the single-tap reverb: signed audio echo with programmable delay length, feedback into the delay line, and separate wet-mix gain.
- Sample-strobed (one sample per `sample_valid`), not one sample per clock. Saturating arithmetic.
- Zeroes its delay memory after reset.
- Sits in the audio path between the sample source and the DAC/output serializer.

---
 rtl/audio_fx_pkg.sv | 31 +++
 rtl/echo_delay_ram.sv | 30 +++
 rtl/feedback_echo.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/audio_fx_pkg.sv
// Shared types and helpers for the audio effect blocks.
//   - state_e  : echo controller states (memory clear, idle, RAM read, compute)
//   - sat_add  : signed add with clamp to a given sample width
//   - *_DEF    : default geometry; PTR_BITS is the address width for the
//                default delay-line depth
package audio_fx_pkg;

  localparam int DATA_BITS_DEF = 16;
  localparam int MAX_DELAY_DEF = 4096;
  localparam int COEF_BITS_DEF = 8;
  localparam int PTR_BITS      = $clog2(MAX_DELAY_DEF);

  typedef enum logic [1:0] {CLEAR, IDLE, READ, CALC} state_e;

  // Adds two sign-extended samples one bit wider than the operands and clamps
  // the result to [-2^(width-1), 2^(width-1)-1]. Valid for width <= 31.
  function automatic logic signed [31:0] sat_add(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int width);
    logic signed [32:0] sum;
    logic signed [32:0] hi;
    logic signed [32:0] lo;
    sum = {a[31], a} + {b[31], b};
    hi  = (33'sd1 <<< (width - 1)) - 33'sd1;
    lo  = -(33'sd1 <<< (width - 1));
    if (sum > hi)      sat_add = hi[31:0];
    else if (sum < lo) sat_add = lo[31:0];
    else               sat_add = sum[31:0];
  endfunction

endpackage

// File: rtl/echo_delay_ram.sv
// Delay-line storage for the echo: single clock, one write port and one
// registered read port. Contents are not reset; the controller clears them.
//   clk      : clock
//   we_i     : write strobe       waddr_i/wdata_i : write address / data
//   re_i     : read strobe        raddr_i         : read address
//   rdata_o  : read data, valid the cycle after re_i, held until next read
module echo_delay_ram #(
  parameter int DATA_BITS = 16,
  parameter int DEPTH     = 4096
) (
  input  logic                         clk,
  input  logic                         we_i,
  input  logic [$clog2(DEPTH)-1:0]     waddr_i,
  input  logic signed [DATA_BITS-1:0]  wdata_i,
  input  logic                         re_i,
  input  logic [$clog2(DEPTH)-1:0]     raddr_i,
  output logic signed [DATA_BITS-1:0]  rdata_o
);

  logic signed [DATA_BITS-1:0] mem [DEPTH];
  logic signed [DATA_BITS-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/feedback_echo.sv
// Sample-strobed signed echo with programmable delay, feedback into the delay
// line and a separate wet-mix gain. Saturating arithmetic throughout.
//   clk, rst      : clock, asynchronous active-high reset
//   enable        : 1 = echo, 0 = bypass (history still recorded)
//   sample_valid  : one-cycle strobe qualifying din / delay_len / coefficients
//   din           : signed input sample
//   delay_len     : echo delay in samples (0 treated as 1)
//   feedback, mix : unsigned gains, value / 2^COEF_BITS
//   dout          : signed output sample, held between dout_valid pulses
//   dout_valid    : one-cycle strobe, three cycles after the accepted strobe
//   busy          : clearing memory or processing a sample
//   overrun       : sticky, a strobe arrived while busy and was dropped
module feedback_echo
  import audio_fx_pkg::*;
#(
  parameter int DATA_BITS = DATA_BITS_DEF,
  parameter int MAX_DELAY = MAX_DELAY_DEF,  // power of two: pointers wrap by truncation
  parameter int COEF_BITS = COEF_BITS_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic                          sample_valid,
  input  logic signed [DATA_BITS-1:0]   din,
  input  logic [$clog2(MAX_DELAY)-1:0]  delay_len,
  input  logic [COEF_BITS-1:0]          feedback,
  input  logic [COEF_BITS-1:0]          mix,
  output logic signed [DATA_BITS-1:0]   dout,
  output logic                          dout_valid,
  output logic                          busy,
  output logic                          overrun
);

  localparam int PTR_W  = $clog2(MAX_DELAY);
  localparam int PROD_W = DATA_BITS + COEF_BITS + 1;

  state_e                      state_q, state_d;
  logic [PTR_W-1:0]            clr_cnt_q, clr_cnt_d;
  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic signed [DATA_BITS-1:0] dout_q, dout_d;
  logic                        dout_valid_q, dout_valid_d;
  logic                        overrun_q, overrun_d;

  // Per-sample operands captured on acceptance.
  logic signed [DATA_BITS-1:0] din_q;
  logic                        en_q;
  logic [COEF_BITS-1:0]        fb_q, mx_q;

  logic                        accept;
  logic [PTR_W-1:0]            eff_len, rd_addr;
  logic                        ram_we, ram_re;
  logic [PTR_W-1:0]            ram_waddr;
  logic signed [DATA_BITS-1:0] ram_wdata, ram_rdata;
  logic signed [PROD_W-1:0]    prod_fb, prod_mx;
  logic signed [DATA_BITS-1:0] p_fb, p_mx, w_calc, y_calc;

  assign accept  = (state_q == IDLE) && sample_valid;
  assign eff_len = (delay_len == '0) ? PTR_W'(1) : delay_len;
  assign rd_addr = wr_ptr_q - eff_len;

  // Coefficients are zero-extended so they act as positive gains.
  // |d * coef / 2^COEF_BITS| < |d|, so the shifted product fits a sample.
  assign prod_fb = PROD_W'(ram_rdata) * PROD_W'($signed({1'b0, fb_q}));
  assign prod_mx = PROD_W'(ram_rdata) * PROD_W'($signed({1'b0, mx_q}));
  assign p_fb    = DATA_BITS'(prod_fb >>> COEF_BITS);
  assign p_mx    = DATA_BITS'(prod_mx >>> COEF_BITS);

  always_comb begin
    w_calc = din_q;
    y_calc = din_q;
    if (en_q) begin
      w_calc = DATA_BITS'(sat_add(32'(din_q), 32'(p_fb), DATA_BITS));
      y_calc = DATA_BITS'(sat_add(32'(din_q), 32'(p_mx), DATA_BITS));
    end
  end

  always_comb begin
    state_d      = state_q;
    clr_cnt_d    = clr_cnt_q;
    wr_ptr_d     = wr_ptr_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    // Any strobe outside IDLE is dropped, including the CALC cycle itself.
    overrun_d    = overrun_q | (sample_valid && (state_q != IDLE));
    ram_we       = 1'b0;
    ram_re       = 1'b0;
    ram_waddr    = wr_ptr_q;
    ram_wdata    = w_calc;
    unique case (state_q)
      CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_cnt_q;
        ram_wdata = '0;
        clr_cnt_d = clr_cnt_q + PTR_W'(1);
        if (clr_cnt_q == PTR_W'(MAX_DELAY - 1)) state_d = IDLE;
      end
      IDLE: begin
        if (accept) begin
          ram_re  = 1'b1;
          state_d = READ;
        end
      end
      READ: state_d = CALC;
      CALC: begin
        ram_we       = 1'b1;
        wr_ptr_d     = wr_ptr_q + PTR_W'(1);
        dout_d       = y_calc;
        dout_valid_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= CLEAR;
      clr_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      din_q <= din;
      en_q  <= enable;
      fb_q  <= feedback;
      mx_q  <= mix;
    end
  end

  echo_delay_ram #(
    .DATA_BITS (DATA_BITS),
    .DEPTH     (MAX_DELAY)
  ) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .waddr_i (ram_waddr),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (rd_addr),
    .rdata_o (ram_rdata)
  );

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q != IDLE);
  assign overrun    = overrun_q;

endmodule
